// File: rtl/nios2_subsystem_fifo_read_ctrl_if.sv
// Avalon-MM slave bus plus audio FIFO read port seen by the read controller.
// No latency of its own; pure signal bundle.
// Backpressure lives in the controller (fifo_rdempty gates rdreq, no Avalon wait states).
interface nios2_subsystem_fifo_read_ctrl_if #(
   parameter int DATA_WIDTH = 16
);
   logic [1:0]            address;
   logic                  chipselect;
   logic                  read;
   logic                  write;
   logic [31:0]           writedata;
   logic [31:0]           readdata;
   logic                  irq;
   logic                  fifo_rdempty;
   logic                  fifo_rdreq;
   logic [DATA_WIDTH-1:0] fifo_q;

   // Controller side
   modport slave (
      input  address, chipselect, read, write, writedata, fifo_rdempty, fifo_q,
      output readdata, irq, fifo_rdreq
   );

   // Environment side: CPU data master plus the FIFO read port
   modport master (
      output address, chipselect, read, write, writedata, fifo_rdempty, fifo_q,
      input  readdata, irq, fifo_rdreq
   );
endinterface

// File: rtl/nios2_subsystem_fifo_read_ctrl.sv
// Sequences single-word reads from the audio FIFO into a holding register popped by the CPU.
// Avalon read latency 1; a FIFO word reaches the holding register 2 cycles after rdreq is raised.
// No wait states; rdreq is withheld while the FIFO is empty or the holding word is unread.
module nios2_subsystem_fifo_read_ctrl #(
   parameter int DATA_WIDTH  = 16,
   parameter int COUNT_WIDTH = 16
) (
   input logic                              clk,
   input logic                              reset_n,
   nios2_subsystem_fifo_read_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_FULL = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [DATA_WIDTH-1:0]  holding_q, holding_d;
   logic                   valid_q, valid_d;
   logic                   enable_q, enable_d;
   logic                   irq_en_q, irq_en_d;
   logic                   underrun_q, underrun_d;
   logic [COUNT_WIDTH-1:0] pop_count_q, pop_count_d;
   logic [31:0]            readdata_q, readdata_d;
   logic                   irq_q, irq_d;
   logic                   fifo_rdreq;

   logic                   rd;
   logic                   wr;
   logic                   pop;
   logic [31:0]            data_word;
   logic [31:0]            status_word;

   assign rd = bus.chipselect & bus.read;
   assign wr = bus.chipselect & bus.write;

   // An empty holding register reads as zero rather than the stale last word.
   assign data_word   = valid_q ? 32'(holding_q) : 32'd0;
   assign status_word = {27'd0, underrun_q, irq_en_q, enable_q, bus.fifo_rdempty, valid_q};

   // Only a DATA read that finds a valid word consumes it.
   assign pop = rd && (bus.address == 2'd0) && valid_q;

   // Next-state: FIFO fetch sequencing, register file access and interrupt level
   always_comb begin
      state_d     = state_q;
      holding_d   = holding_q;
      valid_d     = valid_q;
      enable_d    = enable_q;
      irq_en_d    = irq_en_q;
      underrun_d  = underrun_q;
      pop_count_d = pop_count_q;
      readdata_d  = readdata_q;
      fifo_rdreq  = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            // rdreq is combinational so the FIFO sees it in this same cycle and
            // fifo_q is ready for capture on the following edge.
            if (enable_q && !bus.fifo_rdempty && !valid_q) begin
               fifo_rdreq = 1'b1;
               state_d    = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // The request is already committed, so finish it regardless of enable.
            holding_d = bus.fifo_q;
            valid_d   = 1'b1;
            state_d   = ST_FULL;
         end
         ST_FULL: begin
            if (pop) begin
               valid_d     = 1'b0;
               pop_count_d = pop_count_q + COUNT_WIDTH'(1);
               state_d     = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (rd) begin
         unique case (bus.address)
            2'd0: begin
               readdata_d = data_word;
               if (!valid_q) begin
                  underrun_d = 1'b1;
               end
            end
            2'd1:    readdata_d = status_word;
            2'd2:    readdata_d = {30'd0, irq_en_q, enable_q};
            default: readdata_d = 32'(pop_count_q);
         endcase
      end

      // Writes come last so a COUNT clear beats a same-cycle pop increment.
      if (wr) begin
         unique case (bus.address)
            2'd1: begin
               if (bus.writedata[4]) begin
                  underrun_d = 1'b0;
               end
            end
            2'd2: begin
               enable_d = bus.writedata[0];
               irq_en_d = bus.writedata[1];
            end
            2'd3:    pop_count_d = '0;
            default: ;
         endcase
      end

      irq_d = irq_en_d & valid_d;
   end

   // State and register storage, cleared asynchronously
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         holding_q   <= '0;
         valid_q     <= 1'b0;
         enable_q    <= 1'b0;
         irq_en_q    <= 1'b0;
         underrun_q  <= 1'b0;
         pop_count_q <= '0;
         readdata_q  <= 32'd0;
         irq_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         holding_q   <= holding_d;
         valid_q     <= valid_d;
         enable_q    <= enable_d;
         irq_en_q    <= irq_en_d;
         underrun_q  <= underrun_d;
         pop_count_q <= pop_count_d;
         readdata_q  <= readdata_d;
         irq_q       <= irq_d;
      end
   end

   assign bus.readdata   = readdata_q;
   assign bus.irq        = irq_q;
   assign bus.fifo_rdreq = fifo_rdreq;

endmodule
